rx_inst_queue: RTL and testbench



---
 rtl/rx_inst_queue.sv | 175 +++++++++++++++++
 tb/tb_rx_inst_queue.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_inst_queue.sv
// rx_inst_queue: buffers UART RX bytes in a FIFO and issues them one at a
// time to the sequencer, pacing issue around the UART transmitter.
//
// Ports:
//   clk, rst_n      clock; synchronous active-low reset
//   i_rx_data/valid received byte and its one-cycle strobe
//   i_tx_busy       UART transmitter busy; blocks the next issue
//   i_hold          level; pauses issue while the FIFO keeps filling
//   o_inst/valid    registered instruction and its one-cycle issue strobe
//   o_count         occupancy; o_empty / o_full derived from it
//   o_overflow      sticky; a byte was dropped on a full FIFO
//
// Optional feature macro: RXQ_CMD_FLUSH_EN (byte 0xFF flushes the FIFO).

module rx_inst_queue #(
    parameter int DEPTH   = 8,
    parameter int INST_W  = 8,
    parameter int GAP_CYC = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 i_rx_data,
    input  logic                       i_rx_valid,
    input  logic                       i_tx_busy,
    input  logic                       i_hold,
    output logic [INST_W-1:0]          o_inst,
    output logic                       o_inst_valid,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty,
    output logic                       o_full,
    output logic                       o_overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int GW = $clog2(GAP_CYC + 1);

    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [GW-1:0] GAP_LD = GW'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GAP  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [INST_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     w_wr_idx;
    logic [CW-1:0]     r_count;
    logic [GW-1:0]     r_gap;
    logic [INST_W-1:0] r_inst;
    logic              r_inst_valid;
    logic              r_overflow;

    logic              w_empty;
    logic              w_full;
    logic              w_cmd;
    logic              w_flush;
    logic              w_push;
    logic              w_drop;
    logic              w_issue;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_C);

`ifdef RXQ_CMD_FLUSH_EN
    logic r_flush;

    // 0xFF is a command, not data: it requests a flush on the next edge.
    assign w_cmd   = i_rx_valid && (i_rx_data == 8'hFF);
    assign w_flush = r_flush;

    always_ff @(posedge clk) begin
        if (!rst_n) r_flush <= 1'b0;
        else        r_flush <= w_cmd;
    end
`else
    assign w_cmd   = 1'b0;
    assign w_flush = 1'b0;
`endif

    // Full is judged on the count before any same-cycle pop.
    assign w_push = i_rx_valid && !w_cmd && !w_full;
    assign w_drop = i_rx_valid && !w_cmd && w_full;

    // A push landing on a flush edge becomes the first entry of the new FIFO.
    assign w_wr_idx = w_flush ? '0 : r_wr_ptr;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // FSM: next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_issue)       w_next = S_GAP;
            S_GAP:   if (r_gap == '0)   w_next = S_WAIT;
            S_WAIT:  if (!i_tx_busy)    w_next = S_IDLE;
            default:                    w_next = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_issue = 1'b0;
        if (r_state == S_IDLE && !w_empty && !i_tx_busy && !i_hold)
            w_issue = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_gap <= '0;
        end else if (w_issue) begin
            r_gap <= GAP_LD;
        end else if (r_state == S_GAP && r_gap != '0) begin
            r_gap <= r_gap - GW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inst       <= '0;
            r_inst_valid <= 1'b0;
        end else begin
            r_inst_valid <= w_issue;
            if (w_issue) r_inst <= r_mem[r_rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[w_wr_idx] <= i_rx_data[INST_W-1:0];
    end

    // Flush overrides the pop of the same edge; the issue itself still occurs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= w_push ? PW'(1) : '0;
            r_count  <= w_push ? CW'(1) : '0;
        end else begin
            if (w_push)  r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_issue) r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_issue})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)      r_overflow <= 1'b0;
        else if (w_drop) r_overflow <= 1'b1;
    end

    assign o_inst       = r_inst;
    assign o_inst_valid = r_inst_valid;
    assign o_count      = r_count;
    assign o_empty      = w_empty;
    assign o_full       = w_full;
    assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_rx_inst_queue.sv
// tb_rx_inst_queue: scoreboard bench for rx_inst_queue.
// Expected bytes are queued at push time and checked on each issue strobe.

module tb_rx_inst_queue;

    localparam int DEPTH   = 8;
    localparam int INST_W  = 8;
    localparam int GAP_CYC = 4;
    localparam int SPACE   = GAP_CYC + 2;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic [7:0]        rx_data  = '0;
    logic              rx_valid = 1'b0;
    logic              tx_busy  = 1'b0;
    logic              hold     = 1'b0;
    logic [INST_W-1:0] inst;
    logic              inst_valid;
    logic [3:0]        count;
    logic              empty;
    logic              full;
    logic              ovf;

    int         n_vec    = 0;
    int         n_err    = 0;
    int         cyc      = 0;
    int         n_iss    = 0;
    int         last_iss = -1;
    bit         prev_v   = 1'b0;
    logic [7:0] exp_q[$];
    int         iss_q[$];
    int         n0;
    int         t;
    int         fall;

    rx_inst_queue #(
        .DEPTH  (DEPTH),
        .INST_W (INST_W),
        .GAP_CYC(GAP_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .i_tx_busy   (tx_busy),
        .i_hold      (hold),
        .o_inst      (inst),
        .o_inst_valid(inst_valid),
        .o_count     (count),
        .o_empty     (empty),
        .o_full      (full),
        .o_overflow  (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && inst_valid) begin
            chk("no_back2back", 32'(prev_v), 0);
            chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) chk("inst", 32'(inst), 32'(exp_q.pop_front()));
            if (last_iss >= 0)
                chk("spacing_min", 32'((cyc - last_iss) >= SPACE), 1);
            last_iss = cyc;
            iss_q.push_back(cyc);
            n_iss++;
        end
        prev_v = rst_n && inst_valid;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b, input bit accept);
        rx_data  = b;
        rx_valid = 1'b1;
        if (accept) exp_q.push_back(b);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_drained"}, exp_q.size(), 0);
        tick(10);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_inst"},  32'(inst), 0);
        chk({tag, "_valid"}, 32'(inst_valid), 0);
        chk({tag, "_count"}, 32'(count), 0);
        chk({tag, "_empty"}, 32'(empty), 1);
        chk({tag, "_full"},  32'(full), 0);
        chk({tag, "_ovf"},   32'(ovf), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        rst_n = 1'b1;
        chk_reset("rst");

        // single byte: issue one edge after the push edge
        n0 = n_iss;
        push(8'h41, 1'b1);
        chk("lat_edgeN", 32'(inst_valid), 0);
        tick(1);
        chk("lat_edgeN1", 32'(inst_valid), 1);
        chk("lat_inst", 32'(inst), 32'h41);
        tick(10);
        chk("t1_once", n_iss - n0, 1);
        chk("t1_count", 32'(count), 0);
        chk("t1_empty", 32'(empty), 1);

        // fill to full under hold, overflow, then drain in order
        hold = 1'b1;
        n0   = n_iss;
        for (int i = 1; i <= 8; i++) push(8'(i), 1'b1);
        chk("t2_full", 32'(full), 1);
        chk("t2_count", 32'(count), 8);
        chk("t2_noissue", n_iss - n0, 0);
        push(8'h09, 1'b0);
        chk("t2_ovf", 32'(ovf), 1);
        chk("t2_count_ovf", 32'(count), 8);
        iss_q.delete();
        hold = 1'b0;
        drain("t2");
        chk("t2_n", iss_q.size(), 8);
        for (int i = 1; i < iss_q.size(); i++)
            chk("t2_spacing", iss_q[i] - iss_q[i-1], SPACE);
        chk("t2_ovf_sticky", 32'(ovf), 1);
        chk("t2_empty", 32'(empty), 1);

        // busy after first issue holds back the second
        hold = 1'b1;
        push(8'h10, 1'b1);
        push(8'h20, 1'b1);
        n0   = n_iss;
        hold = 1'b0;
        t    = 0;
        while (n_iss == n0 && t < 50) begin
            tick(1);
            t++;
        end
        chk("t3_first", n_iss - n0, 1);
        tx_busy = 1'b1;
        tick(50);
        chk("t3_held", n_iss - n0, 1);
        tx_busy = 1'b0;
        fall    = cyc;
        t       = 0;
        while (n_iss == n0 + 1 && t < 50) begin
            tick(1);
            t++;
        end
        chk("t3_second", n_iss - n0, 2);
        chk("t3_delay", 32'((iss_q[$] - fall) >= 2), 1);
        tick(10);

        // push and pop on the same edge with count=3
        hold = 1'b1;
        push(8'hA1, 1'b1);
        push(8'hA2, 1'b1);
        push(8'hA3, 1'b1);
        chk("t4_count3", 32'(count), 3);
        n0       = n_iss;
        rx_data  = 8'hA4;
        rx_valid = 1'b1;
        exp_q.push_back(8'hA4);
        hold     = 1'b0;
        tick(1);
        rx_valid = 1'b0;
        chk("t4_issued", 32'(inst_valid), 1);
        chk("t4_count_same", 32'(count), 3);
        drain("t4");

        // pointer wrap: 12 bytes in bursts with hold toggling
        for (int b = 0; b < 3; b++) begin
            hold = 1'b1;
            for (int k = 0; k < 4; k++) push(8'(8'h50 + b * 4 + k), 1'b1);
            hold = 1'b0;
            drain("t4_wrap");
        end

        // reset during GAP with 5 bytes queued
        hold = 1'b1;
        for (int i = 0; i < 6; i++) push(8'(8'h61 + i), 1'b1);
        n0   = n_iss;
        hold = 1'b0;
        t    = 0;
        while (n_iss == n0 && t < 50) begin
            tick(1);
            t++;
        end
        chk("t5_issue", n_iss - n0, 1);
        chk("t5_count5", 32'(count), 5);
        rst_n = 1'b0;
        tick(1);
        rst_n    = 1'b1;
        exp_q.delete();
        last_iss = -1;
        prev_v   = 1'b0;
        chk_reset("t5_rst");
        n0 = n_iss;
        tick(30);
        chk("t5_silent", n_iss - n0, 0);

        // 0xFF handling
        hold = 1'b1;
`ifdef RXQ_CMD_FLUSH_EN
        push(8'h01, 1'b0);
        push(8'h02, 1'b0);
        push(8'hFF, 1'b0);
        tick(2);
        chk("t6_count", 32'(count), 0);
        chk("t6_empty", 32'(empty), 1);
        n0   = n_iss;
        hold = 1'b0;
        tick(20);
        chk("t6_none", n_iss - n0, 0);
`else
        push(8'h01, 1'b1);
        push(8'h02, 1'b1);
        push(8'hFF, 1'b1);
        tick(2);
        chk("t6_count", 32'(count), 3);
        n0   = n_iss;
        hold = 1'b0;
        drain("t6");
        chk("t6_n", n_iss - n0, 3);
`endif
        chk("ovf_final", 32'(ovf), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
